// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt arbiter.
// FSM state encoding, vector width and default source count.
package irq_pkg;

    localparam int VEC_W     = 5;
    localparam int N_SRC_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVICE,
        ST_GAP
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Rotating priority encoder: first set request at or after start,
// wrapping past N-1 back to 0.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N = N_SRC_DEF
) (
    input  logic [N-1:0]     req,
    input  logic [VEC_W-1:0] start,
    output logic             valid,
    output logic [VEC_W-1:0] idx
);

    int j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = VEC_W'(j);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Edge-triggered interrupt arbiter with one-cycle gap between grants.
// Define IRQ_ROUND_ROBIN_EN for rotating priority instead of fixed.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int               N_SRC    = N_SRC_DEF,
    parameter logic [VEC_W-1:0] ISR_BASE = '0,
    parameter logic [N_SRC-1:0] MASK_RST = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] i_irq_src,
    input  logic             i_mask_we,
    input  logic [N_SRC-1:0] i_mask_wdata,
    input  logic             i_reti,
    output logic             o_IRQ,
    output logic [VEC_W-1:0] o_ISR_addr,
    output logic [N_SRC-1:0] o_pending,
    output logic             o_busy
);

    irq_state_e       state;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] edges;
    logic [N_SRC-1:0] clr;
    logic             hist_vld;
    logic             win_vld;
    logic [VEC_W-1:0] win_idx;
    logic [VEC_W-1:0] start_idx;
    logic             grant;

    // History is not trusted until one sample after reset, so a line
    // already high at release does not count as a rising edge.
    assign edges = i_irq_src & ~prev & {N_SRC{hist_vld}};
    assign grant = (state == ST_IDLE) && win_vld;
    assign clr   = grant ? (N_SRC'(1) << win_idx) : '0;

    assign o_pending = pend;
    assign o_busy    = (state != ST_IDLE);

`ifdef IRQ_ROUND_ROBIN_EN
    logic [VEC_W-1:0] rr_ptr;

    assign start_idx = (rr_ptr == VEC_W'(N_SRC - 1)) ? '0
                                                     : rr_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= VEC_W'(N_SRC - 1);
        end else if (grant) begin
            rr_ptr <= win_idx;
        end
    end
`else
    assign start_idx = '0;
`endif

    irq_prio_enc #(
        .N(N_SRC)
    ) u_enc (
        .req  (pend & mask),
        .start(start_idx),
        .valid(win_vld),
        .idx  (win_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev     <= '0;
            hist_vld <= 1'b0;
            pend     <= '0;
            mask     <= MASK_RST;
        end else begin
            prev     <= i_irq_src;
            hist_vld <= 1'b1;
            pend     <= (pend & ~clr) | edges;
            if (i_mask_we) mask <= i_mask_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            o_IRQ      <= 1'b0;
            o_ISR_addr <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state      <= ST_SERVICE;
                        o_IRQ      <= 1'b1;
                        o_ISR_addr <= ISR_BASE + win_idx;
                    end
                end
                ST_SERVICE: begin
                    if (i_reti) begin
                        state <= ST_GAP;
                        o_IRQ <= 1'b0;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    o_IRQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus a
// randomized run, all checked against a per-source behavioural model.
module tb_irq_arbiter;

    localparam int         N    = 8;
    localparam logic [4:0] BASE = 5'd0;

    logic         clk;
    logic         rst;
    logic [N-1:0] src;
    logic         mwe;
    logic [N-1:0] mwd;
    logic         reti;
    logic         irq;
    logic [4:0]   addr;
    logic [N-1:0] pending;
    logic         busy;

    int n_checks;
    int n_fail;

    irq_arbiter #(
        .N_SRC   (N),
        .ISR_BASE(BASE),
        .MASK_RST(8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_irq_src   (src),
        .i_mask_we   (mwe),
        .i_mask_wdata(mwd),
        .i_reti      (reti),
        .o_IRQ       (irq),
        .o_ISR_addr  (addr),
        .o_pending   (pending),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 = idle, 1 = in service, 2 = gap cycle.
    bit m_pend[N];
    bit m_mask[N];
    bit m_prev[N];
    bit m_armed;
    int m_phase;
    int m_win;
    int m_last;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_mask[i] = 1;
            m_prev[i] = 0;
        end
        m_armed = 0;
        m_phase = 0;
        m_win   = 0;
        m_last  = N - 1;
    endtask

    task automatic model_edge();
        int g;
        bit rise[N];
        g = -1;
        if (m_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
`ifdef IRQ_ROUND_ROBIN_EN
                idx = (m_last + 1 + k) % N;
`else
                idx = k;
`endif
                if (g < 0 && m_pend[idx] && m_mask[idx]) g = idx;
            end
        end
        for (int i = 0; i < N; i++)
            rise[i] = m_armed && src[i] && !m_prev[i];
        if (g >= 0) m_pend[g] = 0;
        for (int i = 0; i < N; i++)
            if (rise[i]) m_pend[i] = 1;
        case (m_phase)
            0: if (g >= 0) begin
                m_phase = 1;
                m_win   = g;
                m_last  = g;
            end
            1: if (reti) m_phase = 2;
            default: m_phase = 0;
        endcase
        for (int i = 0; i < N; i++) m_prev[i] = src[i];
        m_armed = 1;
        if (mwe)
            for (int i = 0; i < N; i++) m_mask[i] = mwd[i];
    endtask

    task automatic compare_model();
        logic [31:0] ep;
        ep = 0;
        for (int i = 0; i < N; i++)
            if (m_pend[i]) ep[i] = 1'b1;
        chk("irq", 32'(irq), 32'(m_phase == 1));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("pend", 32'(pending), ep);
        if (m_phase == 1)
            chk("addr", 32'(addr), 32'((int'(BASE) + m_win) % 32));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
        mwe  = 1'b0;
        reti = 1'b0;
    endtask

    task automatic retire();
        reti = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        src = '0;
        model_reset();
        #1;
        chk("rst_irq", 32'(irq), 0);
        chk("rst_pend", 32'(pending), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int seq[$];
    int cnt;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        src  = '0;
        mwe  = 1'b0;
        mwd  = '0;
        reti = 1'b0;
        model_reset();
        #1;
        chk("reset_irq", 32'(irq), 0);
        chk("reset_addr", 32'(addr), 0);
        chk("reset_pend", 32'(pending), 0);
        chk("reset_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        step();

        // single source latency
        src[3] = 1'b1;
        step();
        chk("t034_noirq_k", 32'(irq), 0);
        src[3] = 1'b0;
        step();
        chk("t034_irq", 32'(irq), 1);
        chk("t034_addr", 32'(addr), 3);
        chk("t034_pend3", 32'(pending[3]), 0);
        retire();

`ifndef IRQ_ROUND_ROBIN_EN
        // fixed priority with gap
        src[5] = 1'b1;
        src[2] = 1'b1;
        step();
        src = '0;
        step();
        chk("t035_addr2", 32'(addr), 2);
        reti = 1'b1;
        step();
        chk("t035_gap_irq", 32'(irq), 0);
        chk("t035_gap_busy", 32'(busy), 1);
        cnt = 0;
        while (!irq && cnt < 4) begin
            step();
            cnt++;
        end
        chk("t035_irq5", 32'(irq), 1);
        chk("t035_addr5", 32'(addr), 5);
        retire();
`endif

        // masked source held pending, then released by unmask
        mwe = 1'b1;
        mwd = 8'hFB;
        step();
        src[2] = 1'b1;
        step();
        src[2] = 1'b0;
        step();
        step();
        chk("t036_masked_irq", 32'(irq), 0);
        chk("t036_pend2", 32'(pending[2]), 1);
        mwe = 1'b1;
        mwd = 8'hFF;
        cnt = 0;
        step();
        while (!irq && cnt < 2) begin
            step();
            cnt++;
        end
        chk("t036_irq", 32'(irq), 1);
        chk("t036_addr", 32'(addr), 2);
        retire();

        // new edge on the winner at its own grant edge
        src[0] = 1'b1;
        step();
        src[0] = 1'b0;
        step();
        src[4] = 1'b1;
        step();
        src[4] = 1'b0;
        reti   = 1'b1;
        step();
        step();
        src[4] = 1'b1;
        step();
        chk("t039_addr4", 32'(addr), 4);
        chk("t039_pend4", 32'(pending[4]), 1);
        src[4] = 1'b0;
        reti   = 1'b1;
        step();
        chk("t039_gap", 32'(irq), 0);
        step();
        step();
        chk("t039_again", 32'(irq), 1);
        chk("t039_addr_again", 32'(addr), 4);
        retire();

`ifdef IRQ_ROUND_ROBIN_EN
        // rotating priority alternates between two busy sources
        for (int r = 0; r < 4; r++) begin
            src[0] = 1'b1;
            src[1] = 1'b1;
            step();
            src = '0;
            cnt = 0;
            while (!irq && cnt < 4) begin
                step();
                cnt++;
            end
            seq.push_back(int'(addr));
            retire();
            step();
        end
        for (int r = 1; r < 4; r++)
            chk("t037_alt", 32'(seq[r]), 32'(1 - seq[r-1]));
`endif

        // asynchronous reset in service discards pending work
        src[0] = 1'b1;
        step();
        src[0] = 1'b0;
        step();
        src[4] = 1'b1;
        src[5] = 1'b1;
        step();
        chk("t038_pend30", 32'(pending), 32'h30);
        chk("t038_in_svc", 32'(irq), 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("t038_async_irq", 32'(irq), 0);
        chk("t038_pend0", 32'(pending), 0);
        chk("t038_busy", 32'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) step();
        chk("t038_no_grant", 32'(irq), 0);
        src = '0;
        step();

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) src[i] = ~src[i];
            reti = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) begin
                mwe = 1'b1;
                mwd = N'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
